rr_arbiter_hold: RTL and testbench

Parametrised round-robin arbiter for N requesters with registered one-hot grant, grant hold while the owner keeps requesting, and a bounded hold (MAX_HOLD) that forces rotation under contention. It sits in front of a shared resource (bus, memory port) and replaces fixed 4-channel round-robin state machines where channel count and fairness bound must be configurable.

---
 rtl/rr_arbiter_hold_pkg.sv | 29 ++
 rtl/rr_arbiter_hold_if.sv | 31 +++
 rtl/rr_arbiter_hold_pick.sv | 41 ++++
 rtl/rr_arbiter_hold.sv | 111 +++++++++++
 tb/tb_rr_arbiter_hold.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/rr_arbiter_hold_pkg.sv
// rr_pkg: shared types and helpers for the round-robin hold arbiter.
// Holds the state enum, width helpers for the grant index and hold counter,
// and the index -> one-hot conversion used for the grant vector.
package rr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Largest supported requester count; one-hot helpers are sized for it.
  localparam int MAX_N = 32;

  // Grant index width for n requesters (n is 2..32).
  function automatic int idw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Hold counter width: must represent 0..max_hold inclusive.
  function automatic int cw_of(input int max_hold);
    return $clog2(max_hold + 1);
  endfunction

  // Index to one-hot over the widest supported vector; callers truncate to N.
  function automatic logic [MAX_N-1:0] idx_to_onehot(input logic [4:0] idx);
    return {{(MAX_N-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_hold_if.sv
// rr_arbiter_hold_if: request/grant bundle between N requesters and the arbiter.
// Ports: req (N, from requesters), gnt (N one-hot), gnt_id (IDW), busy (1).
// master = requester side, slave = arbiter side.
interface rr_arbiter_hold_if
  import rr_pkg::*;
#(
  parameter int N = 4
);

  localparam int IDW = idw_of(N);

  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;

  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  busy
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output busy
  );

endinterface

// File: rtl/rr_arbiter_hold_pick.sv
// rr_pick: combinational round-robin pick over a candidate vector.
// Ports: cand (N) candidates, ptr (IDW) last winner; found (1), idx (IDW) winner.
// Scan order is ptr+1, ptr+2, ... wrapping, ptr itself last; zero latency, no backpressure.
module rr_pick
  import rr_pkg::*;
#(
  parameter int N = 4,
  localparam int IDW = idw_of(N)
) (
  input  logic [N-1:0]   cand,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx
);

  logic [N-1:0] rot;
  int           start;
  int           sel;
  int           sum;

  // Rotate {cand,cand} right so that bit ptr+1 lands at position 0; the
  // lowest set bit of the rotated vector is then the round-robin winner.
  always_comb begin
    start = int'(ptr) + 1;
    if (start >= N) start = start - N;
    rot = N'({cand, cand} >> start);

    sel = 0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) sel = j;
    end

    // Undo the rotation to get the absolute index.
    sum = start + sel;
    if (sum >= N) sum = sum - N;

    found = |cand;
    idx   = found ? IDW'(sum) : '0;
  end

endmodule

// File: rtl/rr_arbiter_hold.sv
// rr_arbiter_hold: N-way round-robin arbiter with grant hold and bounded tenure.
// Ports: clk, rst_n (async, active-low), bus (slave: req in; gnt, gnt_id, busy out).
// Latency: grant registered one edge after req; owner holds up to MAX_HOLD cycles
// while others wait, then is rotated out. No backpressure: requesters simply hold req.
module rr_arbiter_hold
  import rr_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_arbiter_hold_if.slave    bus
);

  localparam int IDW = idw_of(N);
  localparam int CW  = cw_of(MAX_HOLD);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(MAX_HOLD);
  localparam logic [IDW-1:0] PTR_INIT = IDW'(N - 1);

  state_t         state;
  logic [IDW-1:0] k;         // current owner
  logic [IDW-1:0] ptr;       // most recently granted index, survives idle
  logic [CW-1:0]  cnt;       // consecutive grant cycles of the current owner
  logic [N-1:0]   gnt_q;
  logic [IDW-1:0] gnt_id_q;
  logic           busy_q;

  logic [N-1:0]   k_mask;
  logic [N-1:0]   cand;
  logic           owner_req;
  logic           hold_done;
  logic           found;
  logic [IDW-1:0] pick_idx;
  logic           take_new;
  logic           go_idle;
  logic           inc;

  always_comb begin
    k_mask    = N'(idx_to_onehot(5'(k)));
    owner_req = |(bus.req & k_mask);
    hold_done = (cnt == CNT_MAX);
    // Forced rotation is the only case where the owner still requests, so
    // its bit must be removed before the pick; on release req[k] is already 0.
    cand = bus.req;
    if (state == OWN && owner_req && hold_done) cand = bus.req & ~k_mask;
  end

  rr_pick #(.N(N)) u_pick (
    .cand  (cand),
    .ptr   (ptr),
    .found (found),
    .idx   (pick_idx)
  );

  always_comb begin
    take_new = 1'b0;
    go_idle  = 1'b0;
    inc      = 1'b0;
    case (state)
      IDLE: take_new = found;
      OWN: begin
        if (!owner_req) begin
          // Hand straight over when someone else waits: no idle bubble.
          take_new = found;
          go_idle  = !found;
        end else if (!hold_done) begin
          inc = 1'b1;
        end else begin
          // Tenure exhausted: rotate if anyone else wants it, otherwise the
          // counter stays saturated so rotation happens on first contention.
          take_new = found;
        end
      end
      default: go_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= '0;
      ptr      <= PTR_INIT;   // index 0 wins first after reset
      cnt      <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
    end else if (take_new) begin
      state    <= OWN;
      k        <= pick_idx;
      ptr      <= pick_idx;
      cnt      <= CW'(1);
      gnt_q    <= N'(idx_to_onehot(5'(pick_idx)));
      gnt_id_q <= pick_idx;
      busy_q   <= 1'b1;
    end else if (go_idle) begin
      state    <= IDLE;
      cnt      <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
    end else if (inc) begin
      cnt      <= cnt + CW'(1);
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// tb_rr_arbiter_hold: directed vector table, reset-mid-grant sequence and
// randomized traffic against a behavioural round-robin model (N=4, MAX_HOLD=4).
module tb_rr_arbiter_hold;

  localparam int N  = 4;
  localparam int MH = 4;

  logic clk;
  logic rst_n;

  rr_arbiter_hold_if #(.N(N)) bif ();

  rr_arbiter_hold #(.N(N), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Behavioural model: owner (-1 = idle), last granted index, tenure length.
  int m_owner;
  int m_last;
  int m_held;

  typedef struct {
    bit         do_rst;
    logic [3:0] req;
    logic [3:0] exp_gnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int onehot_id(input logic [3:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int model_pick(input logic [3:0] c);
    for (int d = 1; d <= N; d++) begin
      int i;
      i = (m_last + d) % N;
      if (c[i]) return i;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_held  = 0;
  endfunction

  function automatic void model_step(input logic [3:0] r);
    logic [3:0] others;
    int p;
    if (m_owner < 0) begin
      p = model_pick(r);
      if (p >= 0) begin m_owner = p; m_last = p; m_held = 1; end
    end else if (!r[m_owner]) begin
      p = model_pick(r);
      if (p >= 0) begin m_owner = p; m_last = p; m_held = 1; end
      else m_owner = -1;
    end else if (m_held < MH) begin
      m_held++;
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      p = model_pick(others);
      if (p >= 0) begin m_owner = p; m_last = p; m_held = 1; end
    end
  endfunction

  function automatic logic [3:0] model_gnt();
    logic [3:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  // Reset pulse placed between edges; outputs checked while reset is held.
  task automatic do_reset(input string nm);
    bif.req = '0;
    rst_n = 1'b0;
    model_reset();
    #2;
    chk({nm, "_rst_gnt"},  32'(bif.gnt),    32'h0);
    chk({nm, "_rst_id"},   32'(bif.gnt_id), 32'h0);
    chk({nm, "_rst_busy"}, 32'(bif.busy),   32'h0);
    rst_n = 1'b1;
    #1;
  endtask

  // One clock: drive req, let the edge sample it, settle 1 time unit after.
  task automatic cyc(input logic [3:0] r);
    bif.req = r;
    @(posedge clk);
    model_step(r);
    #1;
  endtask

  task automatic push(input bit rs, input logic [3:0] r, input logic [3:0] g, input int n);
    for (int i = 0; i < n; i++) begin
      vec_t v;
      v.do_rst  = rs && (i == 0);
      v.req     = r;
      v.exp_gnt = g;
      vecs.push_back(v);
    end
  endtask

  initial begin
    logic [3:0] r;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    bif.req = '0;
    model_reset();
    @(posedge clk);
    #1;

    // Full contention: each owner holds exactly MAX_HOLD cycles, in index order.
    push(1, 4'b1111, 4'b0001, MH);
    push(0, 4'b1111, 4'b0010, MH);
    push(0, 4'b1111, 4'b0100, MH);
    push(0, 4'b1111, 4'b1000, MH);
    push(0, 4'b1111, 4'b0001, 1);
    // Lone requester keeps the grant past MAX_HOLD, then releases to idle.
    push(1, 4'b0100, 4'b0100, 10);
    push(0, 4'b0000, 4'b0000, 1);
    // Owner 1 drops after 2 cycles with 3 waiting: direct handover.
    push(1, 4'b0010, 4'b0010, 1);
    push(0, 4'b1010, 4'b0010, 1);
    push(0, 4'b1000, 4'b1000, 1);
    // Owner 3 releases, idle 5 cycles, 1001 must go to 0 (ptr remembered 3).
    push(0, 4'b0000, 4'b0000, 5);
    push(0, 4'b1001, 4'b0001, 1);
    // Owner 0 saturated, 1 arrives: rotate, then 1 drops and 0 gets it back.
    push(1, 4'b0001, 4'b0001, MH);
    push(0, 4'b0011, 4'b0010, 1);
    push(0, 4'b0001, 4'b0001, 1);

    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      if (vecs[i].do_rst) do_reset(nm);
      cyc(vecs[i].req);
      chk({nm, "_gnt"},  32'(bif.gnt),    32'(vecs[i].exp_gnt));
      chk({nm, "_id"},   32'(bif.gnt_id), 32'(onehot_id(vecs[i].exp_gnt)));
      chk({nm, "_busy"}, 32'(bif.busy),   32'(|vecs[i].exp_gnt));
    end

    // Reset asserted mid-grant: outputs drop without waiting for a clock edge.
    do_reset("midrst_pre");
    cyc(4'b0100);
    chk("midrst_gnt_before", 32'(bif.gnt), 32'h4);
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt_async",  32'(bif.gnt),    32'h0);
    chk("midrst_busy_async", 32'(bif.busy),   32'h0);
    chk("midrst_id_async",   32'(bif.gnt_id), 32'h0);
    model_reset();
    #1;
    rst_n = 1'b1;
    cyc(4'b0100);
    chk("midrst_gnt_after",  32'(bif.gnt),  32'h4);
    chk("midrst_busy_after", 32'(bif.busy), 32'h1);

    // Randomized traffic; requests tend to persist so holds and saturation occur.
    do_reset("rand");
    r = '0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      cyc(r);
      chk($sformatf("rand%0d_gnt", c),  32'(bif.gnt),  32'(model_gnt()));
      chk($sformatf("rand%0d_id", c),   32'(bif.gnt_id),
          32'((m_owner < 0) ? 0 : m_owner));
      chk($sformatf("rand%0d_busy", c), 32'(bif.busy), 32'(m_owner >= 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
